// File: rtl/pconv_scheduler_if.sv
// Result stream between the convolution sequencer and its consumer:
// one accumulated 3x3 result per handshake, tagged with its output row/column.
interface pconv_scheduler_if #(
   parameter int ACC_W = 20
);
   logic             o_valid;
   logic             o_ready;
   logic [ACC_W-1:0] o_data;
   logic [4:0]       o_row;
   logic [4:0]       o_col;

   modport master (output o_valid, output o_data, output o_row, output o_col, input o_ready);
   modport slave  (input o_valid, input o_data, input o_row, input o_col, output o_ready);
endinterface

// File: rtl/pconv_scheduler.sv
// Frame sequencer for a 3-tap partial_conv datapath: for every output pixel of
// a 3x3 valid convolution it fetches the three kernel rows one at a time,
// routes each pixel triple to partial_conv with the matching kernel-row select,
// sums the three partial results and hands the total downstream.
module pconv_scheduler #(
   parameter int IMG_W  = 28,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 24,
   parameter int PSUM_W = 18,
   parameter int ACC_W  = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  img_ren,
   output logic [ADDR_W-1:0]     img_addr,
   input  logic [DATA_W-1:0]     img_rdata,
   output logic [DATA_W-1:0]     pc_data,
   output logic [1:0]            w_sel,
   input  logic [PSUM_W-1:0]     pc_psum,
   pconv_scheduler_if.master     res
);

   typedef enum logic [2:0] {IDLE, RD, MAC, OUT, DONE} state_t;

   // Last valid output row/column index of the (IMG_W-2)^2 result grid.
   localparam logic [4:0] LAST = 5'(IMG_W - 3);

   state_t            state;
   state_t            state_nxt;
   logic [4:0]        row;
   logic [4:0]        col;
   logic [1:0]        k;
   logic [ACC_W-1:0]  acc;
   logic [4:0]        row_k;
   logic [ADDR_W-1:0] rd_addr;
   logic              last_pix;

   // Word address of kernel row k for the current output pixel; each word
   // already carries the three horizontally adjacent pixels col..col+2.
   assign row_k    = row + {3'b000, k};
   assign rd_addr  = ADDR_W'(row_k) * ADDR_W'(IMG_W) + ADDR_W'(col);
   assign last_pix = (row == LAST) && (col == LAST);

   // State register; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode and all outputs, which are pure functions of the state
   // and the position/accumulator registers so they read 0 outside their phase.
   always_comb begin
      state_nxt   = state;
      busy        = 1'b0;
      done        = 1'b0;
      img_ren     = 1'b0;
      img_addr    = '0;
      pc_data     = '0;
      w_sel       = 2'd0;
      res.o_valid = 1'b0;
      res.o_data  = '0;
      res.o_row   = 5'd0;
      res.o_col   = 5'd0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RD;
         end
         RD: begin
            busy      = 1'b1;
            img_ren   = 1'b1;
            img_addr  = rd_addr;
            w_sel     = k;
            state_nxt = MAC;
         end
         MAC: begin
            busy      = 1'b1;
            pc_data   = img_rdata;
            w_sel     = k;
            state_nxt = (k == 2'd2) ? OUT : RD;
         end
         OUT: begin
            busy        = 1'b1;
            res.o_valid = 1'b1;
            res.o_data  = acc;
            res.o_row   = row;
            res.o_col   = col;
            if (res.o_ready) state_nxt = last_pix ? DONE : RD;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Raster position, kernel-row index and partial-sum accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= 5'd0;
         col <= 5'd0;
         k   <= 2'd0;
         acc <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  row <= 5'd0;
                  col <= 5'd0;
                  k   <= 2'd0;
                  acc <= '0;
               end
            end
            MAC: begin
               // Three 18-bit partials cannot exceed 20 bits, so no saturation.
               acc <= acc + {{(ACC_W-PSUM_W){1'b0}}, pc_psum};
               if (k != 2'd2) k <= k + 2'd1;
            end
            OUT: begin
               if (res.o_ready) begin
                  acc <= '0;
                  k   <= 2'd0;
                  if (col == LAST) begin
                     col <= 5'd0;
                     row <= row + 5'd1;
                  end else begin
                     col <= col + 5'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pconv_scheduler.sv
// Bench for pconv_scheduler: image memory and partial_conv behavioural models,
// a golden 3x3 convolution feeding an expected-result queue, table-driven
// constant frames and hand-written backpressure / restart / reset sequences.
module tb_pconv_scheduler;
   localparam int IMG_W  = 28;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 24;
   localparam int PSUM_W = 18;
   localparam int ACC_W  = 20;
   localparam int NOUT   = (IMG_W - 2) * (IMG_W - 2);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              busy, done, img_ren;
   logic [ADDR_W-1:0] img_addr;
   logic [DATA_W-1:0] img_rdata = '0;
   logic [DATA_W-1:0] pc_data;
   logic [1:0]        w_sel;
   logic [PSUM_W-1:0] pc_psum;

   pconv_scheduler_if #(.ACC_W(ACC_W)) res ();

   pconv_scheduler #(
      .IMG_W(IMG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PSUM_W(PSUM_W), .ACC_W(ACC_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .img_ren(img_ren), .img_addr(img_addr), .img_rdata(img_rdata),
      .pc_data(pc_data), .w_sel(w_sel), .pc_psum(pc_psum), .res(res)
   );

   always #5 clk = ~clk;

   logic [7:0] img [0:IMG_W*IMG_W-1];
   logic [7:0] wt  [0:2][0:2];

   // Synchronous image memory: one-cycle read latency, pixel col in the low byte.
   always @(posedge clk)
      if (img_ren)
         img_rdata <= {img[int'(img_addr)+2], img[int'(img_addr)+1], img[int'(img_addr)]};

   // partial_conv model: dot product of the pixel triple with kernel row w_sel.
   int psum_i;
   always_comb begin
      psum_i = int'(pc_data[7:0])   * int'(wt[w_sel][0])
             + int'(pc_data[15:8])  * int'(wt[w_sel][1])
             + int'(pc_data[23:16]) * int'(wt[w_sel][2]);
      pc_psum = PSUM_W'(psum_i);
   end

   typedef struct {
      logic [4:0]       row;
      logic [4:0]       col;
      logic [ACC_W-1:0] data;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [7:0]       pix;
      logic [7:0]       w;
      logic [ACC_W-1:0] exp_data;
   } vec_t;
   vec_t vec [0:2];

   int checks = 0;
   int failures = 0;
   int hs_count = 0;
   int done_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // One clock: monitor the stream on the falling edge, return 1 after the rising edge.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      if (done) done_count++;
      if (res.o_valid && res.o_ready) begin
         hs_count++;
         if (sb.size() == 0) check("unexpected_output", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            check("sb_row", 32'(res.o_row), 32'(e.row));
            check("sb_col", 32'(res.o_col), 32'(e.col));
            check("sb_data", 32'(res.o_data), 32'(e.data));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame();
      int s;
      for (int r = 0; r < IMG_W - 2; r++)
         for (int c = 0; c < IMG_W - 2; c++) begin
            s = 0;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  s += int'(img[(r+i)*IMG_W + c + j]) * int'(wt[i][j]);
            sb.push_back('{row: 5'(r), col: 5'(c), data: ACC_W'(s)});
         end
   endtask

   task automatic fill_random();
      for (int a = 0; a < IMG_W*IMG_W; a++) img[a] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) wt[i][j] = 8'($urandom_range(0, 255));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   // Runs until done is seen, then checks done lasts one cycle and busy falls.
   task automatic finish_frame(input int hs_base, input int done_base);
      int n = 0;
      while (!done && n < 6000) begin cycle(); n++; end
      check("done_seen", 32'(done), 32'd1);
      check("busy_in_done", 32'(busy), 32'd1);
      cycle();
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
      check("handshakes", 32'(hs_count - hs_base), 32'(NOUT));
      check("done_pulses", 32'(done_count - done_base), 32'd1);
      check("sb_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, hs_base, done_base;
      logic [ACC_W+10-1:0] held;

      vec[0] = '{pix: 8'd1,   w: 8'd1,   exp_data: 20'd9};
      vec[1] = '{pix: 8'd255, w: 8'd255, exp_data: 20'd585225};
      vec[2] = '{pix: 8'd2,   w: 8'd3,   exp_data: 20'd54};
      res.o_ready = 1'b1;

      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ren", 32'(img_ren), 32'd0);
      check("rst_valid", 32'(res.o_valid), 32'd0);
      check("rst_addr", 32'(img_addr), 32'd0);
      check("rst_odata", 32'(res.o_data), 32'd0);
      repeat (3) cycle();
      rst_n = 1'b1;
      cycle();

      // Constant frames from the table.
      for (int v = 0; v < 3; v++) begin
         for (int a = 0; a < IMG_W*IMG_W; a++) img[a] = vec[v].pix;
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) wt[i][j] = vec[v].w;
         push_frame();
         hs_base = hs_count;
         done_base = done_count;
         pulse_start();
         n = 1;
         check("first_rd_ren", 32'(img_ren), 32'd1);
         check("first_rd_addr", 32'(img_addr), 32'd0);
         cycle();
         n++;
         check("first_mac_data", pc_data, {8'd0, vec[v].pix, vec[v].pix, vec[v].pix});
         while (!res.o_valid && n < 20) begin cycle(); n++; end
         check("first_latency", 32'(n), 32'd7);
         check("first_data", 32'(res.o_data), 32'(vec[v].exp_data));
         check("first_rowcol", {22'd0, res.o_row, res.o_col}, 32'd0);
         cycle();
         n = 1;
         while (!res.o_valid && n < 20) begin cycle(); n++; end
         check("output_period", 32'(n), 32'd7);
         finish_frame(hs_base, done_base);
      end

      // Random frame: backpressure at (0,5), start ignored at output 100.
      fill_random();
      push_frame();
      hs_base = hs_count;
      done_base = done_count;
      pulse_start();
      n = 0;
      while (!(res.o_valid && res.o_row == 5'd0 && res.o_col == 5'd5) && n < 200) begin
         cycle(); n++;
      end
      check("reach_0_5", 32'(res.o_valid), 32'd1);
      res.o_ready = 1'b0;
      held = {res.o_data, res.o_row, res.o_col};
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("bp_valid", 32'(res.o_valid), 32'd1);
         check("bp_ren", 32'(img_ren), 32'd0);
         check("bp_hold", 32'({res.o_data, res.o_row, res.o_col}), 32'(held));
      end
      res.o_ready = 1'b1;
      cycle();
      check("valid_drop", 32'(res.o_valid), 32'd0);
      n = 1;
      while (!res.o_valid && n < 20) begin cycle(); n++; end
      check("bp_next_gap", 32'(n), 32'd7);
      check("bp_next_col", 32'(res.o_col), 32'd6);
      n = 0;
      while ((hs_count - hs_base) < 100 && n < 2000) begin cycle(); n++; end
      check("reach_100", 32'(hs_count - hs_base), 32'd100);
      pulse_start();
      finish_frame(hs_base, done_base);

      // Reset during the MAC phase of output 50.
      fill_random();
      push_frame();
      hs_base = hs_count;
      done_base = done_count;
      pulse_start();
      n = 0;
      while ((hs_count - hs_base) < 50 && n < 1000) begin cycle(); n++; end
      n = 0;
      while (!img_ren && n < 10) begin cycle(); n++; end
      cycle();
      check("in_mac", {30'd0, busy, img_ren}, 32'd2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ren", 32'(img_ren), 32'd0);
      check("mid_rst_pc", 32'(pc_data), 32'd0);
      check("mid_rst_wsel", 32'(w_sel), 32'd0);
      check("mid_rst_out", {res.o_valid, res.o_data, res.o_row, res.o_col}, 32'd0);
      repeat (3) cycle();
      check("no_done_on_rst", 32'(done_count - done_base), 32'd0);
      rst_n = 1'b1;
      sb.delete();
      cycle();
      push_frame();
      hs_base = hs_count;
      done_base = done_count;
      pulse_start();
      n = 1;
      while (!res.o_valid && n < 20) begin cycle(); n++; end
      check("restart_latency", 32'(n), 32'd7);
      check("restart_rowcol", {22'd0, res.o_row, res.o_col}, 32'd0);
      finish_frame(hs_base, done_base);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pconv_scheduler.md
Name: pconv_scheduler

Overview:
Sequencer that drives the combinational 3-tap partial_conv datapath across a full frame. It computes a 3x3 valid convolution over an IMG_W x IMG_W unsigned 8-bit image. For each output pixel it issues three kernel-row fetches and feeds each 24-bit pixel triple to partial_conv with the matching kernel-row select. It accumulates the three 18-bit partial sums and emits one 20-bit result per output pixel through a valid/ready handshake.

Parameters:
IMG_W, 28, input image width/height in pixels (output is (IMG_W-2) x (IMG_W-2))
ADDR_W, 10, image memory address width (must hold IMG_W*IMG_W-1)
DATA_W, 24, pixel-triple width (3 x 8-bit) fed to partial_conv i_data
PSUM_W, 18, partial_conv o_pconv width
ACC_W, 20, accumulated result width

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  frame start request, sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until DONE exits
done  out  1  one-cycle pulse after the last output handshake
img_ren  out  1  image memory read enable
img_addr  out  ADDR_W  word address = (row+k)*IMG_W + col; word holds pixels col..col+2
img_rdata  in  DATA_W  read data, valid exactly 1 cycle after img_ren
pc_data  out  DATA_W  to partial_conv i_data; equals img_rdata in MAC, else 0
w_sel  out  2  kernel row k (0..2), used by weight store to drive partial_conv i_weight
pc_psum  in  PSUM_W  partial_conv o_pconv, combinational, same cycle as pc_data
o_valid  out  1  result valid
o_ready  in  1  downstream accept
o_data  out  ACC_W  conv result, unsigned
o_row  out  5  output row of o_data
o_col  out  5  output column of o_data

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, img_ren, o_valid=0; img_addr, w_sel, o_data, o_row, o_col, pc_data=0; internal row/col/k/acc=0.
- States: IDLE, RD, MAC, OUT, DONE.
- IDLE:
  - start=1 -> row=0, col=0, k=0, acc=0; go to RD.
  - start in any other state is ignored.
- RD: img_ren=1, img_addr=(row+k)*IMG_W+col, w_sel=k; go to MAC.
- MAC: img_ren=0; pc_data=img_rdata; w_sel=k; acc <= acc + zero-extend(pc_psum).
  - If k==2 -> OUT.
  - Otherwise k++ -> RD.
- OUT: o_valid=1; o_data=acc, o_row=row, o_col=col, all held stable while o_ready=0.
  - On o_valid&&o_ready: o_valid drops next cycle.
  - If row==IMG_W-3 and col==IMG_W-3 -> DONE.
  - Else if col==IMG_W-3 -> col=0, row++; otherwise col++.
  - Then acc=0, k=0 -> RD.
- DONE: done=1 for exactly one cycle, busy=0 next cycle; go to IDLE.
- Latency: start accepted at cycle t -> first o_valid at t+7. With o_ready tied high, one output every 7 cycles, so a frame completes in (IMG_W-2)^2*7 cycles plus 1 DONE cycle.
- Widths:
  - Max psum is 3*255*255=195075, which fits 18 bits.
  - Max sum is 585225, which fits 20 bits, so there is no overflow and no saturation.
  - Max address is (IMG_W-1)*IMG_W+(IMG_W-3) = 781 at the defaults.
- o_ready while o_valid=0 has no effect.
- Reset asserted mid-frame aborts immediately to the reset values. No done pulse is produced, and the partial acc is discarded.
- busy is high in RD, MAC, OUT and DONE.

Test Plan:
- All-ones frame: image pixels=1, all weights=1, start pulse -> first o_valid at start+7 with o_data=9, o_row=0, o_col=0. Outputs appear every 7 cycles thereafter.
- Max values: image=0xFF, weights=0xFF -> each MAC sees pc_psum=195075, and every o_data=585225.
- Backpressure: hold o_ready=0 for 10 cycles at output (0,5) -> o_valid, o_data, o_row and o_col stay stable and img_ren stays 0. Output (0,6) follows 7 cycles after the accepting edge.
- Full frame and ordering: random image and weights, compared against a golden 3x3 model -> exactly 676 handshakes in raster order with row wrap at col=25. done pulses once after (25,25) and busy falls the following cycle.
- start ignored while busy: pulse start at output 100 -> no restart, and the count is still 676.
- Reset mid-frame: drop rst_n during MAC of output 50 -> all outputs 0 immediately and no done pulse. After a new start, the frame restarts from (0,0) with correct values.
